// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b LSB first over WIDTH cycles,
// then presents diff and the final borrow with a one-cycle done pulse.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sa, sb, res;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             load, last, d, br_next;

  // One full-subtractor slice on the current operand LSBs.
  always_comb begin
    d       = sa[0] ^ sb[0] ^ br;
    br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    last    = (cnt == CW'(WIDTH - 1));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Result registers are written only on the final shift, so partial sums
  // never appear on diff/bout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      res  <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else if (load) begin
      sa  <= a;
      sb  <= b;
      res <= '0;
      br  <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      res <= {d, res[WIDTH-1:1]};
      br  <= br_next;
      cnt <= cnt + 1'b1;
      if (last) begin
        diff <= {d, res[WIDTH-1:1]};
        bout <= br_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector and reference-model bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] diff;
  logic         bout, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .diff (diff),
    .bout (bout),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         bout;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Runs one operation from IDLE; checks busy length, result stability during
  // RUN, result, and done pulse width.
  task automatic do_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic [W-1:0] ed, input logic eb);
    int           nbusy = 0;
    int           glitch = 0;
    int           t = 0;
    logic [W-1:0] held;
    @(negedge clk);
    held  = diff;
    a     = va;
    b     = vb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && t < 40) begin
      if (busy) nbusy++;
      if (diff !== held) glitch++;
      t++;
      @(negedge clk);
    end
    check({name, " done_seen"}, 32'(done), 32'd1);
    check({name, " busy_cycles"}, nbusy, W);
    check({name, " diff_hidden_in_run"}, glitch, 0);
    check({name, " diff"}, 32'(diff), 32'(ed));
    check({name, " bout"}, 32'(bout), 32'(eb));
    @(negedge clk);
    check({name, " done_one_cycle"}, 32'(done), 32'd0);
    check({name, " diff_held_idle"}, 32'(diff), 32'(ed));
  endtask

  initial begin
    vecs[0]  = '{8'h05, 8'h03, 8'h02, 1'b0};
    vecs[1]  = '{8'h03, 8'h05, 8'hFE, 1'b1};
    vecs[2]  = '{8'h00, 8'hFF, 8'h01, 1'b1};
    vecs[3]  = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[4]  = '{8'hFF, 8'h00, 8'hFF, 1'b0};
    vecs[5]  = '{8'h80, 8'h01, 8'h7F, 1'b0};
    vecs[6]  = '{8'h01, 8'h80, 8'h81, 1'b1};
    vecs[7]  = '{8'hAA, 8'h55, 8'h55, 1'b0};
    vecs[8]  = '{8'h55, 8'hAA, 8'hAB, 1'b1};
    vecs[9]  = '{8'hFF, 8'hFF, 8'h00, 1'b0};
    vecs[10] = '{8'h7F, 8'h80, 8'hFF, 1'b1};

    // Reset state, with start held high to confirm it is ignored.
    start = 1'b1;
    a = 8'h12;
    b = 8'h34;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset diff", 32'(diff), 0);
    check("reset bout", 32'(bout), 0);
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    check("idle after reset busy", 32'(busy), 0);

    for (int i = 0; i < 11; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].bout);

    // Back-to-back: start held across DONE with new operands.
    begin
      int nbusy = 1;
      int t = 0;
      @(negedge clk);
      a = 8'h05; b = 8'h03; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!done && t < 40) begin t++; @(negedge clk); end
      check("b2b first diff", 32'(diff), 32'h02);
      a = 8'h80; b = 8'h01; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("b2b no gap busy", 32'(busy), 1);
      check("b2b no gap done", 32'(done), 0);
      @(negedge clk);
      t = 0;
      while (!done && t < 40) begin if (busy) nbusy++; t++; @(negedge clk); end
      check("b2b second busy_cycles", nbusy, W);
      check("b2b second diff", 32'(diff), 32'h7F);
      check("b2b second bout", 32'(bout), 0);
    end

    // Start pulse and operand changes during RUN are ignored.
    begin
      int ndone = 0;
      logic [W-1:0] dcap = '0;
      logic bcap = 1'b0;
      repeat (2) @(negedge clk);
      a = 8'hA5; b = 8'h3C; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      a = 8'h11; b = 8'hF0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = 8'h00; b = 8'h01;
      for (int i = 0; i < 30; i++) begin
        if (done) begin ndone++; dcap = diff; bcap = bout; end
        @(negedge clk);
      end
      check("run_ignore done_pulses", ndone, 1);
      check("run_ignore diff", 32'(dcap), 32'h69);
      check("run_ignore bout", 32'(bcap), 0);
    end

    // Reset in the 4th RUN cycle aborts with no done pulse.
    begin
      int ndone = 0;
      a = 8'h03; b = 8'h05; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("abort pre busy", 32'(busy), 1);
      check("abort pre diff held", 32'(diff), 32'h69);
      rst = 1'b1;
      #1;
      check("abort busy", 32'(busy), 0);
      check("abort done", 32'(done), 0);
      check("abort diff", 32'(diff), 0);
      check("abort bout", 32'(bout), 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (done) ndone++;
        @(negedge clk);
      end
      check("abort no done", ndone, 0);
      do_op("after_abort", 8'h03, 8'h05, 8'hFE, 1'b1);
    end

    // Reference-model run.
    begin
      int nbad = 0;
      int t;
      logic [W-1:0] ra, rb;
      for (int i = 0; i < 1000; i++) begin
        ra = W'($urandom);
        rb = W'($urandom);
        @(negedge clk);
        a = ra; b = rb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!done && t < 40) begin t++; @(negedge clk); end
        if (!done || diff !== W'(ra - rb) || bout !== (ra < rb)) begin
          nbad++;
          if (nbad <= 5)
            $display("FAIL random a=%0h b=%0h: got diff=%0h bout=%0b done=%0b, expected diff=%0h bout=%0b",
                     ra, rb, diff, bout, done, W'(ra - rb), ra < rb);
        end
      end
      check("random mismatches", nbad, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to begin a subtraction, sampled on rising clk.
REQ-005 SHALL have port a, input, WIDTH bits: minuend, captured when start is accepted.
REQ-006 SHALL have port b, input, WIDTH bits: subtrahend, captured when start is accepted.
REQ-007 SHALL have port diff, output, WIDTH bits: result a - b modulo 2^WIDTH.
REQ-008 SHALL have port bout, output, 1 bit: final borrow; 1 when a < b as unsigned values.
REQ-009 SHALL have port busy, output, 1 bit: high while a subtraction is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when diff and bout are valid.

Function
REQ-011 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-012 In IDLE or DONE, start=1 at a rising edge SHALL capture a and b into internal shift registers, clear the borrow flop, clear the bit counter and enter RUN.
REQ-013 In RUN, each rising edge SHALL process one bit, LSB first: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
REQ-014 Each RUN cycle SHALL shift both operand registers right by one bit and shift d into the result register at the MSB, so the result is LSB-aligned after WIDTH shifts.
REQ-015 A counter of width clog2(WIDTH)+1 SHALL count shifts; after the WIDTH-th shift edge the FSM SHALL enter DONE.
REQ-016 Latency: with start sampled at edge k, done SHALL be high during the cycle following edge k+WIDTH, for exactly one cycle.
REQ-017 DONE with start=0 SHALL return to IDLE on the next edge; DONE with start=1 SHALL begin a new operation (back-to-back, no idle cycle).
REQ-018 busy SHALL be high only in RUN; done SHALL be high only in DONE.
REQ-019 start asserted while in RUN SHALL be ignored; changes on a and b during RUN SHALL NOT affect the result.
REQ-020 diff and bout SHALL update only on the transition into DONE and SHALL hold their values through IDLE until the next operation completes.
REQ-021 Intermediate partial results SHALL NOT be visible on diff or bout during RUN.
REQ-022 There SHALL be no unreachable or illegal states; any undefined encoding SHALL recover to IDLE on the next edge.

Reset
REQ-023 rst=1 SHALL immediately, without waiting for clk, force the FSM to IDLE and clear diff, bout, busy, done, the borrow flop, the counter and the operand registers.
REQ-024 Reset asserted during RUN SHALL abort the operation; no done pulse SHALL follow for that operation.
REQ-025 start SHALL be ignored while rst=1; the first accepted start SHALL be at the first rising edge after rst deasserts.

Verification
REQ-026 WIDTH=8, a=5, b=3, start pulse -> after 8 busy cycles, done=1 with diff=8'h02 and bout=0.
REQ-027 a=3, b=5 -> diff=8'hFE, bout=1; a=8'h00, b=8'hFF -> diff=8'h01, bout=1; a=b=0 -> diff=0, bout=0.
REQ-028 Start held high across DONE with new operands a=8'h80, b=8'h01 -> second operation starts with no gap and yields diff=8'h7F, bout=0.
REQ-029 During RUN, pulse start and change a and b -> the result equals that of the originally captured operands, and exactly one done pulse occurs.
REQ-030 Assert rst at the 4th RUN cycle -> busy, done, diff and bout all go to 0 immediately, and no done pulse follows; a subsequent start completes correctly.
REQ-031 Randomized run of 1000 operand pairs compared against a reference model (a - b) mod 256 with borrow = (a < b); no mismatches allowed.
